// File: rtl/nibble_demux6.sv
// nibble_demux6: steers a valid/ready nibble stream into six
// one-entry output channels; selects 6/7 are dropped and counted.
module nibble_demux6 #(
  parameter int DATA_W = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [5:0]        out_valid,
  input  logic [5:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic [DATA_W-1:0] out_data5,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              drop_pulse
);

  logic [5:0]        valid_q;
  logic [5:0]        valid_d;
  logic [5:0]        sel_hit;
  logic [5:0]        load;
  logic [DATA_W-1:0] data_q [6];
  logic [DROP_W-1:0] drop_cnt_q;
  logic [DROP_W-1:0] drop_cnt_d;
  logic              drop_pulse_q;
  logic              drop_pulse_d;
  logic              drop_sel;
  logic              accept;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < 6; k++) begin
      if (in_sel == 3'(k)) sel_hit[k] = 1'b1;
    end
    drop_sel = in_sel[2] & in_sel[1];
    // a full channel still accepts when its consumer drains this cycle
    in_ready = drop_sel
             | (|(sel_hit & (~valid_q | out_ready)));
    accept = in_valid & in_ready;
    load = sel_hit & {6{accept}};
    valid_d = (valid_q & ~out_ready) | load;
    drop_pulse_d = accept & drop_sel;
    drop_cnt_d = drop_cnt_q;
    if (drop_pulse_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      valid_q      <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      for (int k = 0; k < 6; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign out_data4  = data_q[4];
  assign out_data5  = data_q[5];
  assign drop_cnt   = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_nibble_demux6.sv
// tb_nibble_demux6: directed stimulus with a per-channel
// scoreboard popped by a monitor on every output drain.
module tb_nibble_demux6;

  logic       clk;
  logic       areset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [3:0] in_data;
  logic [5:0] out_valid;
  logic [5:0] out_ready;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [7:0] drop_cnt;
  logic       drop_pulse;

  typedef logic [3:0] nib_q_t [$];
  nib_q_t exp_q [6];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drops = 0;
  int waits;

  nibble_demux6 #(.DATA_W(4), .DROP_W(8)) dut (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(d0), .out_data1(d1), .out_data2(d2),
    .out_data3(d3), .out_data4(d4), .out_data5(d5),
    .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dout(int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      3: return d3;
      4: return d4;
      default: return d5;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // monitor: every drain pops the oldest expected nibble
  always @(negedge clk) begin
    if (areset_n) begin
      for (int k = 0; k < 6; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_ch%0d: got %0h expected none",
                     k, dout(k));
          end else begin
            chk($sformatf("drain_ch%0d", k),
                32'(dout(k)), 32'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accept
  task automatic send(input int sel, input logic [3:0] dat,
                      output int nw);
    nw = 0;
    in_valid = 1'b1;
    in_sel   = 3'(sel);
    in_data  = dat;
    forever begin
      #1;
      if (in_ready) begin
        if (sel < 6) exp_q[sel].push_back(dat);
        else if (exp_drops < 255) exp_drops++;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      nw++;
      if (nw > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got stalled expected accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '1;
    tick(2);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data2", 32'(d2), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_drop_pulse", 32'(drop_pulse), 0);
    @(negedge clk);
    areset_n = 1'b1;
    tick(1);

    // simple routing
    send(2, 4'hA, waits);
    chk("route_valid", 32'(out_valid), 32'h04);
    chk("route_data2", 32'(d2), 32'hA);
    tick(1);
    chk("route_valid_clr", 32'(out_valid), 0);
    chk("route_data2_hold", 32'(d2), 32'hA);

    // back-pressure isolation
    out_ready = 6'b110111;
    send(3, 4'h5, waits);
    in_sel = 3'd3;
    #1;
    chk("bp_ready_ch3", 32'(in_ready), 0);
    send(1, 4'h7, waits);
    chk("bp_ch1_waits", 32'(waits), 0);
    chk("bp_ch1_valid", 32'(out_valid[1]), 1);
    chk("bp_ch1_data", 32'(d1), 32'h7);
    fork
      send(3, 4'h6, waits);
      begin
        tick(3);
        out_ready = '1;
      end
    join
    chk("bp_ch3_stalled", 32'(waits > 0), 1);
    chk("bp_ch3_data", 32'(d3), 32'h6);
    tick(2);
    chk("bp_drained", 32'(out_valid), 0);

    // streaming: back-to-back into channel 0
    for (int i = 0; i < 8; i++) begin
      send(0, 4'(i), waits);
      chk($sformatf("stream_wait%0d", i), 32'(waits), 0);
      chk($sformatf("stream_v%0d", i), 32'(out_valid[0]), 1);
      chk($sformatf("stream_d%0d", i), 32'(d0), 32'(i));
    end
    tick(1);
    chk("stream_end", 32'(out_valid), 0);

    // drop path
    send(6, 4'hF, waits);
    chk("drop6_wait", 32'(waits), 0);
    chk("drop6_pulse", 32'(drop_pulse), 1);
    chk("drop6_valid", 32'(out_valid), 0);
    send(7, 4'hE, waits);
    chk("drop7_wait", 32'(waits), 0);
    chk("drop7_pulse", 32'(drop_pulse), 1);
    chk("drop7_valid", 32'(out_valid), 0);
    chk("drop_cnt2", 32'(drop_cnt), 2);
    tick(1);
    chk("drop_pulse_low", 32'(drop_pulse), 0);
    for (int i = 0; i < 300; i++) send(6, 4'h1, waits);
    chk("drop_sat_cnt", 32'(drop_cnt), 255);
    chk("drop_sat_model", 32'(drop_cnt), 32'(exp_drops));
    chk("drop_sat_pulse", 32'(drop_pulse), 1);

    // async reset with stalled channels
    out_ready = '0;
    send(0, 4'h3, waits);
    send(4, 4'h9, waits);
    chk("pre_rst_valid", 32'(out_valid), 32'h11);
    @(negedge clk);
    #1;
    areset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data0", 32'(d0), 0);
    chk("arst_data4", 32'(d4), 0);
    chk("arst_drop_cnt", 32'(drop_cnt), 0);
    chk("arst_drop_pulse", 32'(drop_pulse), 0);
    for (int k = 0; k < 6; k++) exp_q[k].delete();
    exp_drops = 0;
    areset_n = 1'b1;
    out_ready = '1;
    send(5, 4'hC, waits);
    chk("post_rst_wait", 32'(waits), 0);
    chk("post_rst_valid", 32'(out_valid), 32'h20);
    chk("post_rst_data5", 32'(d5), 32'hC);
    tick(2);

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sb_empty%0d", k), 32'(exp_q[k].size()), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
